// File: rtl/pe_pkg.sv
// Shared types for the priority bit streamer.
// The FSM has two states: no beat held, or a beat presented on the output.
package pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_bit_streamer_first_bit.sv
// Combinational finder for the first set bit of a vector in scan order.
// Scan order runs LSB-up when MSB_FIRST=0 and MSB-down when MSB_FIRST=1.
module pe_first_bit #(
    parameter int WIDTH      = 16,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    function automatic logic [IDX_W-1:0] scan_pos(input int i);
        return MSB_FIRST ? IDX_W'(WIDTH - 1 - i) : IDX_W'(i);
    endfunction

    // The found flag blocks later hits, so the earliest position in scan order wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && vec[scan_pos(i)]) begin
                found                 = 1'b1;
                onehot[scan_pos(i)]   = 1'b1;
                idx                   = scan_pos(i);
            end
        end
    end

endmodule

// File: rtl/priority_bit_streamer.sv
// Streams every set bit of an accepted word as one output beat per cycle,
// with valid/ready handshakes on both the word input and the beat output.
module priority_bit_streamer
    import pe_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             zero_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] residual_q, residual_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             zero_q, zero_d;

    logic             in_acc;
    logic             out_acc;
    logic [WIDTH-1:0] scan_vec;
    logic [WIDTH-1:0] fb_onehot;
    logic [IDX_W-1:0] fb_idx;
    logic             fb_found;

    assign data_val_o   = (state_q == EMIT);
    assign data_ready_o = !data_val_o || (data_ready_i && last_q);
    assign in_acc       = data_val_i && data_ready_o;
    assign out_acc      = data_val_o && data_ready_i;

    // A fresh word always takes the finder; otherwise it walks the residual.
    assign scan_vec = in_acc ? data_i : residual_q;

    pe_first_bit #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_first_bit (
        .vec    (scan_vec),
        .onehot (fb_onehot),
        .idx    (fb_idx),
        .found  (fb_found)
    );

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        last_d     = last_q;
        zero_d     = zero_q;
        if (in_acc) begin
            state_d    = EMIT;
            onehot_d   = fb_onehot;
            idx_d      = fb_idx;
            zero_d     = !fb_found;
            residual_d = data_i & ~fb_onehot;
            last_d     = (residual_d == '0);
        end else if (out_acc) begin
            if (!last_q) begin
                onehot_d   = fb_onehot;
                idx_d      = fb_idx;
                zero_d     = 1'b0;
                residual_d = residual_q & ~fb_onehot;
                last_d     = (residual_d == '0);
            end else begin
                state_d    = IDLE;
                onehot_d   = '0;
                idx_d      = '0;
                zero_d     = 1'b0;
                last_d     = 1'b0;
                residual_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            residual_q <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            zero_q     <= zero_d;
        end
    end

    assign onehot_o = onehot_q;
    assign idx_o    = idx_q;
    assign last_o   = last_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_priority_bit_streamer.sv
// Bench for priority_bit_streamer: LSB-first and MSB-first instances share one
// stimulus stream; per-instance scoreboards hold the beats each word should produce.
module tb_priority_bit_streamer;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] onehot;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             zero;
    } beat_t;

    logic             clk;
    logic             srst_i;
    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             data_ready_i;

    logic             ready_l, val_l, last_l, zero_l;
    logic [WIDTH-1:0] onehot_l;
    logic [IDX_W-1:0] idx_l;
    logic             ready_m, val_m, last_m, zero_m;
    logic [WIDTH-1:0] onehot_m;
    logic [IDX_W-1:0] idx_m;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    cyc_log[$];
    beat_t exp_l[$];
    beat_t exp_m[$];
    beat_t obs_l, obs_m, want;

    priority_bit_streamer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_ready_o(ready_l), .onehot_o(onehot_l), .idx_o(idx_l), .last_o(last_l),
        .zero_o(zero_l), .data_val_o(val_l), .data_ready_i(data_ready_i)
    );

    priority_bit_streamer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_ready_o(ready_m), .onehot_o(onehot_m), .idx_o(idx_m), .last_o(last_m),
        .zero_o(zero_m), .data_val_o(val_m), .data_ready_i(data_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected beat list for one word in both scan orders.
    task automatic push_word(input logic [WIDTH-1:0] w);
        int    cnt;
        int    n;
        beat_t b;
        cnt = $countones(w);
        if (w == '0) begin
            b = '{onehot: '0, idx: '0, last: 1'b1, zero: 1'b1};
            exp_l.push_back(b);
            exp_m.push_back(b);
        end else begin
            n = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (w[i]) begin
                    n++;
                    b = '{onehot: '0, idx: IDX_W'(i), last: (n == cnt), zero: 1'b0};
                    b.onehot[i] = 1'b1;
                    exp_l.push_back(b);
                end
            end
            n = 0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (w[i]) begin
                    n++;
                    b = '{onehot: '0, idx: IDX_W'(i), last: (n == cnt), zero: 1'b0};
                    b.onehot[i] = 1'b1;
                    exp_m.push_back(b);
                end
            end
        end
    endtask

    // Presents a word and returns just after the edge that accepted it; valid stays high.
    task automatic apply_word(input logic [WIDTH-1:0] w);
        int   n;
        logic rdy;
        data_i     = w;
        data_val_i = 1'b1;
        push_word(w);
        n = 0;
        do begin
            @(negedge clk);
            rdy = ready_l;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        check_output("accept", 32'(rdy), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_l.size() != 0 || exp_m.size() != 0 || val_l !== 1'b0 || val_m !== 1'b0)
               && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("drain", 32'(exp_l.size() == 0 && exp_m.size() == 0
                                  && val_l === 1'b0 && val_m === 1'b0), 32'd1);
    endtask

    // Scoreboard: every accepted beat must match the head of its instance's queue.
    always @(negedge clk) begin
        if (val_l === 1'b1 && data_ready_i === 1'b1) begin
            cyc_log.push_back(cyc);
            obs_l = {onehot_l, idx_l, last_l, zero_l};
            obs_m = {onehot_m, idx_m, last_m, zero_m};
            checks++;
            if (exp_l.size() == 0) begin
                failures++;
                $error("[TB] FAIL beat_lsb unexpected observed=%h expected=none", obs_l);
            end else begin
                want = exp_l.pop_front();
                assert (obs_l === want) else begin
                    failures++;
                    $error("[TB] FAIL beat_lsb observed=%h expected=%h", obs_l, want);
                end
            end
            checks++;
            if (exp_m.size() == 0) begin
                failures++;
                $error("[TB] FAIL beat_msb unexpected observed=%h expected=none", obs_m);
            end else begin
                want = exp_m.pop_front();
                assert (obs_m === want) else begin
                    failures++;
                    $error("[TB] FAIL beat_msb observed=%h expected=%h", obs_m, want);
                end
            end
            if (last_l === 1'b1) begin
                checks++;
                assert (ready_l === 1'b1) else begin
                    failures++;
                    $error("[TB] FAIL ready_on_last observed=%b expected=1", ready_l);
                end
            end
        end
    end

    initial begin
        srst_i       = 1'b1;
        data_i       = '0;
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst_i = 1'b0;

        @(negedge clk);
        check_output("rst_val",    32'(val_l),    32'd0);
        check_output("rst_onehot", 32'(onehot_l), 32'd0);
        check_output("rst_idx",    32'(idx_l),    32'd0);
        check_output("rst_last",   32'(last_l),   32'd0);
        check_output("rst_zero",   32'(zero_l),   32'd0);
        check_output("rst_ready",  32'(ready_l),  32'd1);
        check_output("rst_val_m",  32'(val_m),    32'd0);
        @(posedge clk);
        #1;

        apply_word(8'hA4);
        data_val_i = 1'b0;
        drain();

        apply_word(8'hFF);
        data_val_i = 1'b0;
        drain();

        apply_word(8'h00);
        data_val_i = 1'b0;
        drain();
        @(negedge clk);
        check_output("zero_then_idle", 32'(val_l), 32'd0);
        @(posedge clk);
        #1;

        cyc_log.delete();
        apply_word(8'h81);
        apply_word(8'h01);
        data_val_i = 1'b0;
        drain();
        check_output("b2b_beats", 32'(cyc_log.size()), 32'd3);
        if (cyc_log.size() == 3) begin
            check_output("b2b_gap1", 32'(cyc_log[1] - cyc_log[0]), 32'd1);
            check_output("b2b_gap2", 32'(cyc_log[2] - cyc_log[1]), 32'd1);
        end

        data_ready_i = 1'b0;
        apply_word(8'h0F);
        data_val_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("stall_val",    32'(val_l),    32'd1);
            check_output("stall_idx",    32'(idx_l),    32'd0);
            check_output("stall_onehot", 32'(onehot_l), 32'h01);
            check_output("stall_idx_m",  32'(idx_m),    32'd3);
            check_output("stall_ready",  32'(ready_l),  32'd0);
            @(posedge clk);
            #1;
        end
        data_ready_i = 1'b1;
        drain();

        apply_word(8'hF0);
        data_val_i = 1'b0;
        srst_i     = 1'b1;
        @(posedge clk);
        #1;
        srst_i = 1'b0;
        exp_l.delete();
        exp_m.delete();
        @(negedge clk);
        check_output("srst_val",   32'(val_l),   32'd0);
        check_output("srst_ready", 32'(ready_l), 32'd1);
        check_output("srst_val_m", 32'(val_m),   32'd0);
        @(posedge clk);
        #1;
        apply_word(8'h10);
        data_val_i = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
